// File: rtl/shift_ring_ctr_pkg.sv
// ---------------------------------------------------------------------------
// shift_ring_ctr_pkg
// Shared types and helpers for the RING / JOHNSON shift counter.
//   ctr_mode_e        : counter mode (RING one-hot rotate, JOHNSON twisted ring)
//   DIR_LSB / DIR_MSB : values of the dir input
//   MAX_WIDTH         : widest counter the seed helper can describe
//   seed()            : restart value for a given mode
// ---------------------------------------------------------------------------
package shift_ring_ctr_pkg;

    typedef enum logic {
        CTR_RING    = 1'b0,
        CTR_JOHNSON = 1'b1
    } ctr_mode_e;

    localparam logic DIR_LSB = 1'b0;
    localparam logic DIR_MSB = 1'b1;

    localparam int MAX_WIDTH = 64;

    // Seed of a mode: RING starts with only bit 0 set, JOHNSON starts all-zero.
    // The result is MAX_WIDTH wide; callers cast it down to their own width.
    function automatic logic [MAX_WIDTH-1:0] seed(input ctr_mode_e mode,
                                                 input int unsigned width);
        logic [MAX_WIDTH-1:0] value;
        value = '0;
        if (mode == CTR_RING && width > 0) begin
            value[0] = 1'b1;
        end
        return value;
    endfunction

endpackage

// File: rtl/shift_ring_chk.sv
// ---------------------------------------------------------------------------
// shift_ring_chk
// Combinational legality checker for the shift counter state.
//   mode_q  in  : mode currently in effect
//   out     in  : counter state (WIDTH bits)
//   illegal out : 1 when out is not a state of mode_q's sequence
// RING legal states have exactly one bit set. JOHNSON legal states are
// thermometer codes, i.e. at most one adjacent-bit transition.
// ---------------------------------------------------------------------------
module shift_ring_chk
    import shift_ring_ctr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  ctr_mode_e          mode_q,
    input  logic [WIDTH-1:0]   out,
    output logic               illegal
);

    int ones;
    int edges;

    // XOR of each bit with its neighbour marks every transition in the word.
    assign ones  = $countones(out);
    assign edges = $countones(out[WIDTH-1:1] ^ out[WIDTH-2:0]);

    assign illegal = (mode_q == CTR_RING) ? (ones != 1) : (edges > 1);

endmodule

// File: rtl/shift_ring_ctr.sv
// ---------------------------------------------------------------------------
// shift_ring_ctr
// WIDTH-bit shift counter with RING (one-hot) and JOHNSON (twisted ring)
// modes, runtime direction, enable, parallel load and a registered wrap pulse.
//   clk       in  : clock, state updates on rising edge
//   rstn      in  : asynchronous active-low reset
//   en        in  : shift enable
//   dir       in  : 0 shift toward LSB, 1 shift toward MSB
//   mode      in  : requested mode; a change restarts the counter at its seed
//   load      in  : parallel load strobe (highest priority)
//   load_val  in  : value written on load
//   out       out : counter state (registered)
//   wrap      out : one-cycle pulse when a shift lands back on the mode seed
//   err       out : one-cycle pulse when an illegal state was replaced
// Optional build macro SHIFT_RING_CTR_SELFCHECK_EN enables illegal-state
// correction; without it err is constant 0 and illegal states circulate.
// ---------------------------------------------------------------------------
module shift_ring_ctr
    import shift_ring_ctr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               en,
    input  logic               dir,
    input  ctr_mode_e          mode,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    output logic [WIDTH-1:0]   out,
    output logic               wrap,
    output logic               err
);

    if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("shift_ring_ctr: WIDTH must be in 2..%0d", MAX_WIDTH);
    end

    localparam logic [WIDTH-1:0] RING_SEED    = WIDTH'(seed(CTR_RING, WIDTH));
    localparam logic [WIDTH-1:0] JOHNSON_SEED = WIDTH'(seed(CTR_JOHNSON, WIDTH));

    ctr_mode_e          mode_q;
    logic               twist;
    logic [WIDTH-1:0]   shifted;
    logic [WIDTH-1:0]   cur_seed;
    logic [WIDTH-1:0]   new_seed;
    logic               illegal;

`ifdef SHIFT_RING_CTR_SELFCHECK_EN
    shift_ring_chk #(
        .WIDTH   (WIDTH)
    ) u_chk (
        .mode_q  (mode_q),
        .out     (out),
        .illegal (illegal)
    );
`else
    assign illegal = 1'b0;
`endif

    // JOHNSON inverts the bit that wraps around the end; RING passes it through.
    assign twist    = (mode_q == CTR_JOHNSON);
    assign cur_seed = (mode_q == CTR_RING) ? RING_SEED : JOHNSON_SEED;
    assign new_seed = (mode   == CTR_RING) ? RING_SEED : JOHNSON_SEED;

    // Next value for a shift in the current mode and requested direction.
    always_comb begin
        shifted = out;
        if (dir == DIR_MSB) begin
            shifted = {out[WIDTH-2:0], out[WIDTH-1] ^ twist};
        end else begin
            shifted = {out[0] ^ twist, out[WIDTH-1:1]};
        end
    end

    // Counter state with strict priority: load, mode restart, illegal-state
    // correction, shift, hold. wrap and err default low so they are pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out    <= RING_SEED;
            mode_q <= CTR_RING;
            wrap   <= 1'b0;
            err    <= 1'b0;
        end else begin
            wrap <= 1'b0;
            err  <= 1'b0;
            if (load) begin
                out    <= load_val;
                mode_q <= mode;
            end else if (mode != mode_q) begin
                out    <= new_seed;
                mode_q <= mode;
            end else if (illegal) begin
                out <= cur_seed;
                err <= 1'b1;
            end else if (en) begin
                out  <= shifted;
                wrap <= (shifted == cur_seed);
            end
        end
    end

endmodule

// File: tb/tb_shift_ring_ctr.sv
// ---------------------------------------------------------------------------
// tb_shift_ring_ctr
// Scoreboard bench for shift_ring_ctr (WIDTH=4). The stimulus task computes
// the expected outputs from a behavioural model and queues them; a monitor
// pops one entry after every clock edge and compares it with the DUT.
// ---------------------------------------------------------------------------
module tb_shift_ring_ctr;
    import shift_ring_ctr_pkg::*;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] out;
        logic         wrap;
        logic         err;
    } exp_t;

    logic           clk;
    logic           rstn;
    logic           en;
    logic           dir;
    ctr_mode_e      mode;
    logic           load;
    logic [W-1:0]   loadVal;
    logic [W-1:0]   out;
    logic           wrap;
    logic           err;

    exp_t           expQ[$];
    int             checks;
    int             errors;

    // model state
    logic [W-1:0]   mOut;
    ctr_mode_e      mMode;

`ifdef SHIFT_RING_CTR_SELFCHECK_EN
    localparam bit SELFCHECK = 1'b1;
`else
    localparam bit SELFCHECK = 1'b0;
`endif

    shift_ring_ctr #(.WIDTH(W)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .dir      (dir),
        .mode     (mode),
        .load     (load),
        .load_val (loadVal),
        .out      (out),
        .wrap     (wrap),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [W-1:0] modelSeed(input ctr_mode_e m);
        return (m == CTR_RING) ? W'(1) : W'(0);
    endfunction

    function automatic bit modelLegal(input logic [W-1:0] v, input ctr_mode_e m);
        int n;
        n = 0;
        if (m == CTR_RING) begin
            for (int i = 0; i < W; i++) n += int'(v[i]);
            return n == 1;
        end
        for (int i = 0; i < W - 1; i++) if (v[i] != v[i+1]) n++;
        return n <= 1;
    endfunction

    // Rotate by arithmetic: the bit leaving one end re-enters at the other,
    // inverted in JOHNSON mode.
    function automatic logic [W-1:0] modelShift(input logic [W-1:0] v, input logic d,
                                                input ctr_mode_e m);
        int unsigned x, fill;
        x = v;
        if (d == 1'b0) begin
            fill = x % 2;
            if (m == CTR_JOHNSON) fill = 1 - fill;
            x = (x / 2) + fill * (1 << (W - 1));
        end else begin
            fill = (x / (1 << (W - 1))) % 2;
            if (m == CTR_JOHNSON) fill = 1 - fill;
            x = ((x * 2) + fill) % (1 << W);
        end
        return W'(x);
    endfunction

    task automatic checkValue(input string name, input logic [W-1:0] act,
                              input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: actual=%b required=%b at %0t", name, act, req, $time);
        end
    endtask

    task automatic checkOutput(input string name, input logic [W-1:0] eOut,
                               input logic eWrap, input logic eErr);
        checkValue({name, ".out"}, out, eOut);
        checkValue({name, ".wrap"}, W'(wrap), W'(eWrap));
        checkValue({name, ".err"}, W'(err), W'(eErr));
    endtask

    task automatic afterEdge();
        @(posedge clk);
        #2;
    endtask

    // Drive one cycle of inputs at the falling edge and queue the result the
    // model predicts for the following rising edge.
    task automatic applyStimulus(input logic sEn, input logic sDir, input ctr_mode_e sMode,
                                 input logic sLoad, input logic [W-1:0] sVal);
        exp_t e;
        @(negedge clk);
        en      = sEn;
        dir     = sDir;
        mode    = sMode;
        load    = sLoad;
        loadVal = sVal;
        e.wrap  = 1'b0;
        e.err   = 1'b0;
        if (sLoad) begin
            mOut  = sVal;
            mMode = sMode;
        end else if (sMode != mMode) begin
            mMode = sMode;
            mOut  = modelSeed(sMode);
        end else if (SELFCHECK && !modelLegal(mOut, mMode)) begin
            mOut  = modelSeed(mMode);
            e.err = 1'b1;
        end else if (sEn) begin
            mOut   = modelShift(mOut, sDir, mMode);
            e.wrap = (mOut == modelSeed(mMode));
        end
        e.out = mOut;
        expQ.push_back(e);
    endtask

    // Monitor: one queued expectation per rising edge while out of reset.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rstn && expQ.size() > 0) begin
                e = expQ.pop_front();
                checkValue("mon.out", out, e.out);
                checkValue("mon.wrap", W'(wrap), W'(e.wrap));
                checkValue("mon.err", W'(err), W'(e.err));
            end
        end
    end

    task automatic modelReset();
        mOut  = modelSeed(CTR_RING);
        mMode = CTR_RING;
    endtask

    initial begin
        ctr_mode_e rMode;
        checks  = 0;
        errors  = 0;
        rstn    = 1'b0;
        en      = 1'b0;
        dir     = DIR_LSB;
        mode    = CTR_RING;
        load    = 1'b0;
        loadVal = '0;
        modelReset();

        #12;
        checkOutput("reset", 4'b0001, 1'b0, 1'b0);
        afterEdge();
        rstn = 1'b1;

        // RING toward LSB: wrap only with the fourth-edge return to 0001
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, DIR_LSB, CTR_RING, 1'b0, '0);
        afterEdge();
        checkOutput("ring_lsb_wrap", 4'b0001, 1'b1, 1'b0);

        // JOHNSON restart, then a full LSB-direction period
        applyStimulus(1'b1, DIR_LSB, CTR_JOHNSON, 1'b0, '0);
        afterEdge();
        checkOutput("johnson_restart", 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, DIR_LSB, CTR_JOHNSON, 1'b0, '0);
        afterEdge();
        checkOutput("johnson_lsb_wrap", 4'b0000, 1'b1, 1'b0);

        // Both modes toward MSB
        applyStimulus(1'b1, DIR_MSB, CTR_RING, 1'b0, '0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, DIR_MSB, CTR_RING, 1'b0, '0);
        applyStimulus(1'b1, DIR_MSB, CTR_JOHNSON, 1'b0, '0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, DIR_MSB, CTR_JOHNSON, 1'b0, '0);

        // Illegal RING load
        applyStimulus(1'b0, DIR_LSB, CTR_RING, 1'b1, 4'b0110);
        afterEdge();
        checkOutput("illegal_load", 4'b0110, 1'b0, 1'b0);
        applyStimulus(1'b0, DIR_LSB, CTR_RING, 1'b0, '0);
        afterEdge();
        if (SELFCHECK) checkOutput("illegal_fix", 4'b0001, 1'b0, 1'b1);
        else           checkOutput("illegal_hold", 4'b0110, 1'b0, 1'b0);
        applyStimulus(1'b1, DIR_LSB, CTR_RING, 1'b0, '0);
        applyStimulus(1'b0, DIR_LSB, CTR_RING, 1'b0, '0);

        // Load beats mode change; mode change alone restarts at the seed
        applyStimulus(1'b0, DIR_LSB, CTR_RING, 1'b1, 4'b0100);
        applyStimulus(1'b1, DIR_LSB, CTR_JOHNSON, 1'b1, 4'b0011);
        afterEdge();
        checkOutput("load_vs_mode", 4'b0011, 1'b0, 1'b0);
        applyStimulus(1'b0, DIR_LSB, CTR_RING, 1'b1, 4'b0100);
        applyStimulus(1'b1, DIR_LSB, CTR_JOHNSON, 1'b0, '0);
        afterEdge();
        checkOutput("mode_restart", 4'b0000, 1'b0, 1'b0);

        // Reset between edges with a wrap pending
        applyStimulus(1'b0, DIR_LSB, CTR_RING, 1'b1, 4'b0010);
        @(negedge clk);
        en   = 1'b1;
        load = 1'b0;
        #1;
        rstn = 1'b0;
        #1;
        checkOutput("async_reset", 4'b0001, 1'b0, 1'b0);
        modelReset();
        afterEdge();
        checkOutput("reset_hold", 4'b0001, 1'b0, 1'b0);
        rstn = 1'b1;

        // Randomized traffic against the model
        rMode = CTR_RING;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) rMode = ctr_mode_e'($urandom_range(0, 1));
            applyStimulus(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), rMode,
                          ($urandom_range(0, 15) == 0), W'($urandom_range(0, 15)));
        end

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
        #3;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: actual=%0d pending required=0", expQ.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
